cook_sequencer: RTL

//   Upstream controller for the microwave PWM stage. Runs the cook session: idle/run/pause/done FSM,

---
 rtl/cook_pkg.sv | 16 +
 rtl/strobe_div.sv | 36 +++
 rtl/cook_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cook_pkg.sv
// Shared state encoding for the cook session sequencer.
package cook_pkg;
    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } cook_state_e;
endpackage

// File: rtl/strobe_div.sv
// Enabled prescaler counting 0..DIV-1 with synchronous clear.
// tick_o is combinational: high in the enabled cycle whose edge wraps the count.
module strobe_div #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_top;

    assign at_top = (cnt_q == CW'(DIV - 1));
    assign tick_o = en_i && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cook_sequencer.sv
// Cook session controller: idle/run/pause/done FSM, seconds countdown and PWM strobes.
// All outputs registered; prescalers only advance while in RUN, so paused time is not counted.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter int TIME_BITS  = 8,
    parameter int PERIOD_DIV = 3125000,
    parameter int SEC_DIV    = 50000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 cancel,
    input  logic                 door_open,
    input  logic [TIME_BITS-1:0] cook_time,
    input  logic [NUM_BITS-1:0]  power_level,
    output logic                 period_strobe,
    output logic                 sec_strobe,
    output logic [NUM_BITS-1:0]  duty,
    output logic                 run_en,
    output logic [TIME_BITS-1:0] time_left,
    output logic [ST_W-1:0]      state,
    output logic                 done
);
    cook_state_e          state_q, state_d;
    logic [TIME_BITS-1:0] time_q, time_d;
    logic [NUM_BITS-1:0]  duty_q, duty_d;
    logic                 run_en_q, run_en_d;
    logic                 done_q, done_d;
    logic                 pstb_q, sstb_q;
    logic                 prescale_en, prescale_clr;
    logic                 per_tick, sec_tick;

    // A cancelled RUN cycle neither counts time nor emits strobes.
    assign prescale_en = (state_q == S_RUN) && !cancel;

    strobe_div #(.DIV(PERIOD_DIV)) u_period_div (
        .clock  (clock),
        .reset  (reset),
        .en_i   (prescale_en),
        .clr_i  (prescale_clr),
        .tick_o (per_tick)
    );

    strobe_div #(.DIV(SEC_DIV)) u_sec_div (
        .clock  (clock),
        .reset  (reset),
        .en_i   (prescale_en),
        .clr_i  (prescale_clr),
        .tick_o (sec_tick)
    );

    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        duty_d       = duty_q;
        prescale_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !door_open && (cook_time != '0)) begin
                    state_d      = S_RUN;
                    time_d       = cook_time;
                    duty_d       = power_level;
                    prescale_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (sec_tick) begin
                    time_d = time_q - TIME_BITS'(1);
                end
                // Expiry of the last second outranks door and pause.
                if (sec_tick && (time_q == TIME_BITS'(1))) begin
                    state_d = S_DONE;
                end else if (door_open || pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start && !door_open) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                time_d  = '0;
                duty_d  = '0;
            end
        endcase

        if (cancel) begin
            state_d = S_IDLE;
            time_d  = '0;
            duty_d  = '0;
        end

        run_en_d = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            time_q   <= '0;
            duty_q   <= '0;
            run_en_q <= 1'b0;
            done_q   <= 1'b0;
            pstb_q   <= 1'b0;
            sstb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            duty_q   <= duty_d;
            run_en_q <= run_en_d;
            done_q   <= done_d;
            pstb_q   <= per_tick;
            sstb_q   <= sec_tick;
        end
    end

    assign period_strobe = pstb_q;
    assign sec_strobe    = sstb_q;
    assign duty          = duty_q;
    assign run_en        = run_en_q;
    assign time_left     = time_q;
    assign state         = state_q;
    assign done          = done_q;
endmodule
